// File: rtl/des_align_pkg.sv
// Shared definitions for the deserializer byte aligner: FSM encoding and default training byte.
package des_align_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_PAT_DEFAULT = 8'hB8;

endpackage

// File: rtl/sync_detect_4.sv
// Combinational search of the four byte candidates in an 11-bit window; lowest offset wins.
module sync_detect_4 (
    input  logic [10:0] i_win,
    input  logic [7:0]  i_pat,
    output logic        o_hit,
    output logic [1:0]  o_b
);

    always_comb begin
        o_hit = 1'b0;
        o_b   = 2'd0;
        // Descending scan so the lowest matching offset is the one left standing.
        for (int b = 3; b >= 0; b--) begin
            if (i_win[b +: 8] == i_pat) begin
                o_hit = 1'b1;
                o_b   = 2'(b);
            end
        end
    end

endmodule

// File: rtl/des_word_align.sv
// Byte aligner behind the 2-to-4 deserializer: locks to a repeated training byte,
// then emits one aligned byte per two consumed nibbles.
module des_word_align
    import des_align_pkg::*;
#(
    parameter logic [7:0] SyncPat  = SYNC_PAT_DEFAULT,
    parameter int         LockCnt  = 4,
    parameter int         CntWidth = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_dat,
    input  logic       i_vld,
    input  logic       i_realign,
    output logic [7:0] o_dat,
    output logic       o_vld,
    output logic       o_lock,
    output logic [2:0] o_offset
);

    localparam logic [CntWidth-1:0] LOCK_TGT = CntWidth'(LockCnt);
    localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);

    logic [6:0]          r_hist;
    logic                r_ph;
    logic                r_warm;
    state_t              r_state;
    logic [CntWidth-1:0] r_cnt;
    logic [1:0]          r_b_sel;
    logic                r_ph_sel;
    logic [7:0]          r_dat;
    logic                r_vld;
    logic                r_lock;
    logic [2:0]          r_off;

    logic [10:0]         w_win;
    logic                w_hit;
    logic [1:0]          w_b;
    logic [7:0]          w_sel;
    logic                w_slot;
    logic                w_match;
    logic [2:0]          w_off;
    logic [CntWidth-1:0] w_cnt_inc;

    assign w_win     = {i_dat, r_hist};
    assign w_sel     = w_win[r_b_sel +: 8];
    assign w_slot    = i_vld & (r_ph == r_ph_sel);
    assign w_match   = (w_sel == SyncPat);
    // {ph, b} is 4*ph + b; the +1 accounts for the window starting one bit past a nibble pair.
    assign w_off     = {r_ph, w_b} + 3'd1;
    assign w_cnt_inc = r_cnt + CNT_ONE;

    sync_detect_4 u_det (
        .i_win (w_win),
        .i_pat (SyncPat),
        .o_hit (w_hit),
        .o_b   (w_b)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist   <= '0;
            r_ph     <= 1'b0;
            r_warm   <= 1'b0;
            r_state  <= ST_SEARCH;
            r_cnt    <= '0;
            r_b_sel  <= 2'd0;
            r_ph_sel <= 1'b0;
            r_dat    <= 8'd0;
            r_vld    <= 1'b0;
            r_lock   <= 1'b0;
            r_off    <= 3'd0;
        end else begin
            r_vld <= 1'b0;
            if (i_vld) begin
                r_hist <= w_win[10:4];
                r_ph   <= ~r_ph;
                if (r_ph) r_warm <= 1'b1;
            end

            // Realign keeps the bit history so the next search can start immediately.
            if (i_realign) begin
                r_state <= ST_SEARCH;
                r_cnt   <= '0;
                r_lock  <= 1'b0;
            end else if (i_vld) begin
                case (r_state)
                    ST_SEARCH: begin
                        if (r_warm && w_hit) begin
                            r_b_sel  <= w_b;
                            r_ph_sel <= r_ph;
                            r_cnt    <= CNT_ONE;
                            r_off    <= w_off;
                            if (LockCnt == 1) begin
                                r_state <= ST_LOCKED;
                                r_lock  <= 1'b1;
                            end else begin
                                r_state <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (w_slot) begin
                            if (w_match) begin
                                r_cnt <= w_cnt_inc;
                                if (w_cnt_inc == LOCK_TGT) begin
                                    r_state <= ST_LOCKED;
                                    r_lock  <= 1'b1;
                                end
                            end else begin
                                r_state <= ST_SEARCH;
                                r_cnt   <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_slot) begin
                            r_dat <= w_sel;
                            r_vld <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                        r_cnt   <= '0;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_dat    = r_dat;
    assign o_vld    = r_vld;
    assign o_lock   = r_lock;
    assign o_offset = r_off;

endmodule

// File: tb/tb_des_word_align.sv
// Directed bench for des_word_align: table of bit-stream scenarios plus reset/realign sequences.
module tb_des_word_align;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] i_dat = 4'd0;
    logic       i_vld = 1'b0;
    logic       i_realign = 1'b0;
    logic [7:0] o_dat;
    logic       o_vld;
    logic       o_lock;
    logic [2:0] o_offset;

    always #5 clk = ~clk;

    des_word_align dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_dat     (i_dat),
        .i_vld     (i_vld),
        .i_realign (i_realign),
        .o_dat     (o_dat),
        .o_vld     (o_vld),
        .o_lock    (o_lock),
        .o_offset  (o_offset)
    );

    typedef struct {
        int          slip;
        int          nbytes;
        logic [95:0] bytes;
        bit          gaps;
        int          ra_nib;
        int          exp_off;
        int          exp_lock;
        int          exp_nout;
        int          exp_first;
        logic [7:0]  exp_first_dat;
        int          exp_last;
        logic [7:0]  exp_last_dat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] s_dat;
    logic       s_vld, s_lock;
    logic [2:0] s_off;

    logic       sb[0:255];
    int         nbits;
    logic       lock_at[0:63];
    logic       vld_at[0:63];
    logic [7:0] dat_at[0:63];
    logic [2:0] off_at[0:63];
    int         stray;

    function automatic vec_t mk(int slip, int nb, logic [95:0] by, bit gaps, int ra,
                                int off, int lk, int nout, int f, logic [7:0] fd,
                                int l, logic [7:0] ld);
        vec_t v;
        v.slip = slip; v.nbytes = nb; v.bytes = by; v.gaps = gaps; v.ra_nib = ra;
        v.exp_off = off; v.exp_lock = lk; v.exp_nout = nout;
        v.exp_first = f; v.exp_first_dat = fd; v.exp_last = l; v.exp_last_dat = ld;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] d, input logic v, input logic ra, input logic r);
        i_dat = d; i_vld = v; i_realign = ra; rst = r;
        @(posedge clk);
        #1;
        s_dat = o_dat; s_vld = o_vld; s_lock = o_lock; s_off = o_offset;
    endtask

    task automatic build(input int slip, input int nb, input logic [95:0] by);
        for (int i = 0; i < 256; i++) sb[i] = 1'b0;
        nbits = slip + 8 * nb;
        for (int j = 0; j < nb; j++)
            for (int k = 0; k < 8; k++)
                sb[slip + 8 * j + k] = by[8 * j + k];
    endtask

    task automatic run(input bit gaps, input int ra_nib, output int nnib);
        nnib  = (nbits + 3) / 4;
        stray = 0;
        for (int n = 0; n < nnib; n++) begin
            step({sb[4*n+3], sb[4*n+2], sb[4*n+1], sb[4*n]}, 1'b1, (n == ra_nib), 1'b0);
            lock_at[n] = s_lock; vld_at[n] = s_vld; dat_at[n] = s_dat; off_at[n] = s_off;
            if (s_vld && !s_lock) stray++;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    step(4'($urandom), 1'b0, 1'b0, 1'b0);
                    if (s_vld) stray++;
                end
            end
        end
        repeat (2) begin
            step(4'h0, 1'b0, 1'b0, 1'b0);
            if (s_vld) stray++;
        end
    endtask

    initial begin
        int nnib, lock_nib, nout, first, last, prev, spacing;
        logic [7:0] fdat, ldat;

        // slip, nbytes, bytes(byte0 in LSBs), gaps, realign nib, offset, lock nib, #out, first nib/dat, last nib/dat
        for (int s = 0; s < 8; s++) begin
            vecs[s] = mk(s, 6, {48'd0, {6{8'hB8}}}, 1'b0, -1, s,
                         (s == 0 || s >= 5) ? 9 : 8,
                         (s == 0) ? 1 : 2,
                         (s == 0 || s >= 5) ? 11 : 10, 8'hB8,
                         (s == 0) ? 11 : ((s >= 5) ? 13 : 12), 8'hB8);
        end
        vecs[8]  = mk(3, 6, {48'd0, 8'hC3, 8'h5A, {4{8'hB8}}}, 1'b0, -1, 3, 8, 2, 10, 8'h5A, 12, 8'hC3);
        vecs[9]  = mk(5, 8, {32'd0, {5{8'hB8}}, 8'h00, 8'hB8, 8'hB8}, 1'b0, -1, 5, 15, 1, 17, 8'hB8, 17, 8'hB8);
        vecs[10] = mk(5, 12, {12{8'hB8}}, 1'b0, 11, 5, 19, 3, 21, 8'hB8, 25, 8'hB8);
        vecs[11] = mk(2, 6, {48'd0, {6{8'hB8}}}, 1'b1, -1, 2, 8, 2, 10, 8'hB8, 12, 8'hB8);

        step(4'h0, 1'b0, 1'b0, 1'b1);
        chk("rst o_dat", s_dat, 0);
        chk("rst o_vld", s_vld, 0);
        chk("rst o_lock", s_lock, 0);
        chk("rst o_offset", s_off, 0);

        for (int i = 0; i < NV; i++) begin
            step(4'hF, 1'b1, 1'b0, 1'b1);
            build(vecs[i].slip, vecs[i].nbytes, vecs[i].bytes);
            run(vecs[i].gaps, vecs[i].ra_nib, nnib);

            lock_nib = -1; nout = 0; first = -1; last = -1; prev = -1; spacing = 0;
            fdat = 8'd0; ldat = 8'd0;
            for (int n = 0; n < nnib; n++) begin
                if (lock_at[n] && (n == 0 || !lock_at[n-1])) lock_nib = n;
                if (vld_at[n]) begin
                    if (prev >= 0 && n - prev != 2) spacing++;
                    prev = n;
                    if (nout == 0) begin first = n; fdat = dat_at[n]; end
                    last = n; ldat = dat_at[n];
                    nout++;
                end
            end
            chk($sformatf("v%0d lock_nib", i), lock_nib, vecs[i].exp_lock);
            chk($sformatf("v%0d offset", i), off_at[nnib-1], vecs[i].exp_off);
            chk($sformatf("v%0d n_out", i), nout, vecs[i].exp_nout);
            chk($sformatf("v%0d first_nib", i), first, vecs[i].exp_first);
            chk($sformatf("v%0d first_dat", i), fdat, vecs[i].exp_first_dat);
            chk($sformatf("v%0d last_nib", i), last, vecs[i].exp_last);
            chk($sformatf("v%0d last_dat", i), ldat, vecs[i].exp_last_dat);
            chk($sformatf("v%0d stray_vld", i), stray, 0);
            chk($sformatf("v%0d spacing", i), spacing, 0);
            if (vecs[i].ra_nib > 0) begin
                chk($sformatf("v%0d lock_before_ra", i), lock_at[vecs[i].ra_nib-1], 1);
                chk($sformatf("v%0d lock_after_ra", i), lock_at[vecs[i].ra_nib], 0);
                chk($sformatf("v%0d vld_on_ra_slot", i), vld_at[vecs[i].ra_nib], 0);
            end
        end

        // The last vector leaves the aligner locked; reset it with a live nibble on the input.
        chk("pre_rst lock", s_lock, 1);
        chk("pre_rst dat", s_dat, 8'hB8);
        step(4'hF, 1'b1, 1'b0, 1'b1);
        chk("mid_rst o_dat", s_dat, 0);
        chk("mid_rst o_vld", s_vld, 0);
        chk("mid_rst o_lock", s_lock, 0);
        chk("mid_rst o_offset", s_off, 0);

        build(5, 6, {48'd0, {6{8'hB8}}});
        run(1'b0, -1, nnib);
        chk("main off nib2", off_at[2], 0);
        chk("main off nib3", off_at[3], 5);
        chk("main lock nib3", lock_at[3], 0);
        chk("main lock nib8", lock_at[8], 0);
        chk("main lock nib9", lock_at[9], 1);
        chk("main vld nib10", vld_at[10], 0);
        chk("main vld nib11", vld_at[11], 1);
        chk("main dat nib11", dat_at[11], 8'hB8);
        chk("main vld nib12", vld_at[12], 0);
        chk("main vld nib13", vld_at[13], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/des_word_align.md
Name: des_word_align

Overview:
- Byte aligner placed directly downstream of the 2-to-4 deserializer, in the divided-by-2 clock domain.
- Collects the 4-bit deserialized nibbles and locks byte boundaries to a repeated training pattern SyncPat. Stream bit order: nibble bit 0 is the earliest bit.
- Once locked, emits one aligned byte every two valid nibbles to the downstream backend.
- Re-entry to search is on request (i_realign) or reset.

Parameters:
SyncPat, 8'hB8, training byte; its LSB is the first bit in the stream.
LockCnt, 4, consecutive SyncPat matches needed to declare lock, counting the first detection.
CntWidth, 3, width of the verify counter; must satisfy 2**CntWidth > LockCnt.

Ports:
i_clk  input  1  clock, the deserializer's o_clk_div_2
i_rst  input  1  reset; synchronous, active-high
i_dat  input  4  deserialized nibble; bit 0 is the earliest bit
i_vld  input  1  i_dat qualifier; nibble consumed on the edge where i_vld=1
i_realign  input  1  one-cycle request to drop lock and re-search
o_dat  output  8  aligned byte; bit 0 is the earliest bit
o_vld  output  1  one-cycle pulse marking o_dat valid
o_lock  output  1  high in LOCKED state
o_offset  output  3  stream bit position (mod 8) of the locked byte start

Behaviour:
- Reset values on i_rst=1 at a clock edge:
  - hist=0, ph=0, warm=0, state=SEARCH, cnt=0.
  - o_dat=0, o_vld=0, o_lock=0, o_offset=0.
  - Reset has priority over every other input, including mid-lock.
- Window:
  - hist[6:0] holds the 7 previous bits; hist[6] is the newest.
  - win[10:0] = {i_dat, hist}.
  - Candidate at bit offset b (0..3) = win[b+7:b].
- On i_vld=1: hist <= win[10:4] and ph <= ~ph. warm <= 1 once two nibbles have been consumed.
- i_vld=0: all state holds and o_vld=0.
- Slot: a cycle where i_vld=1 and ph equals the stored ph_sel.
- SEARCH:
  - Active on each i_vld with warm=1.
  - Compare all four candidates to SyncPat.
  - On any match, take the lowest matching b. Latch b_sel=b and ph_sel=ph, set cnt=1, and go to VERIFY.
  - If LockCnt=1, go directly to LOCKED instead.
- VERIFY:
  - On each slot, compare win[b_sel+7:b_sel].
  - Match: cnt++. When cnt reaches LockCnt, go to LOCKED.
  - Mismatch: go to SEARCH with cnt=0. No new detection is made in that cycle.
- LOCKED:
  - o_lock=1.
  - On each slot: o_dat <= win[b_sel+7:b_sel], and o_vld=1 on the following cycle (latency 1 edge).
  - There is no content checking in LOCKED.
- o_offset:
  - Registered as (4*ph_sel + b_sel + 1) mod 8 when the match is latched.
  - This equals the byte-start bit index mod 8, counted from the first nibble after reset.
- o_lock, o_offset and cnt update on the same edge as the state change.
- i_realign=1 in any state: next state SEARCH, cnt=0, o_lock=0, o_vld=0.
  - i_realign beats a same-cycle match or slot.
  - hist, ph and warm are kept.
- o_vld is never asserted outside LOCKED. The first o_vld comes on the first slot after entering LOCKED.

Decomposition:
- Shared package des_align_pkg holds:
  - state encoding localparams ST_SEARCH=2'd0, ST_VERIFY=2'd1, ST_LOCKED=2'd2;
  - the default SyncPat.
- One sub-module, sync_detect_4 (combinational):
  - inputs: win[10:0] and the pattern;
  - outputs: hit, plus b[1:0] with lowest-offset priority.
- The FSM, counter and output register live in des_word_align.

Test Plan:
- Reset, then 5 zero bits followed by repeated 0xB8 (LSB first), i_vld=1 continuously:
  - detection on the 4th nibble, with o_offset=5 and o_lock rising after 4 bytes;
  - o_dat=0xB8 with o_vld on every 2nd cycle thereafter.
- Sweep bit slips 0..7 of the same stream: o_offset equals the slip each time, and o_dat=0xB8 once locked.
- Lock at slip 3, then drive payload 0x5A,0xC3: o_dat=0x5A then 0xC3, each one edge after its completing nibble.
- 0xB8 x2, then a corrupted byte 0x00, then 0xB8 x4:
  - VERIFY aborts to SEARCH, re-detects and locks;
  - o_vld stays 0 until lock.
- While LOCKED, pulse i_realign in the same cycle as a slot:
  - no o_vld, o_lock=0 next cycle;
  - relocks after 4 matching bytes.
- Insert random i_vld=0 gaps during training, then assert i_rst mid-LOCKED:
  - lock and offset are unaffected by the gaps;
  - after reset, all outputs are 0 and the FSM is in SEARCH.
